memory_sram_adapter: RTL and testbench
======================================

# memory_sram_adapter

Downstream stage of the memory arbiter: accepts the single arbitrated request (enable/ready four-phase handshake, byte/half/word size) and drives a 32-bit word-wide synchronous SRAM with byte enables. Splits accesses that cross a word boundary into two SRAM transactions, steers byte lanes, and returns zero-extended read data.

## Interface
- SIZE, 32: address width; data path fixed at 32 bits.
- READ_LATENCY, 1: cycles from SRAM strobe to valid sram_read_data; must be ≥1.

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- memory_enable  in  1  request held by the arbiter until ready observed.
- memory_operation  in  1  0 = read, 1 = write.
- memory_ready  out  1  access complete; held until memory_enable drops.
- memory_data_size  in  2  0 = byte, 1 = half, 2 = word, 3 = treated as word.
- memory_address  in  SIZE  byte address; any alignment.
- memory_data_in  out  32  read result, zero-extended, valid while memory_ready.
- memory_data_out  in  32  write data in low bytes.
- sram_enable  out  1  one-cycle strobe per SRAM transaction.
- sram_write  out  1  qualifies strobe as write.
- sram_address  out  SIZE-2  word address.
- sram_byte_enable  out  4  lane mask; bit n = bits 8n+7:8n.
- sram_write_data  out  32  lane-aligned write data.
- sram_read_data  in  32  read word, READ_LATENCY after strobe.

## Operation
- States: IDLE, ACCESS_LOW, WAIT_LOW, ACCESS_HIGH, WAIT_HIGH, DONE.
- IDLE: memory_enable high → latch operation, size, address, data_out; go ACCESS_LOW.
- Byte count n = 1/2/4; offset o = address[1:0]; split when o+n > 4.
- ACCESS_LOW: strobe word address[SIZE-1:2], byte_enable = ((1<<n)-1)<<o truncated to 4 bits, write data = data_out<<(8o). Read → WAIT_LOW; write → ACCESS_HIGH if split else DONE.
- WAIT_LOW: count READ_LATENCY cycles from strobe, capture low word; → ACCESS_HIGH if split else DONE.
- ACCESS_HIGH: word address+1 (wraps all-ones → 0), byte_enable = (1<<(o+n-4))-1, write data = data_out>>(8(4-o)). Read → WAIT_HIGH; write → DONE.
- WAIT_HIGH: capture high word; → DONE.
- Read result: {high,low} 64-bit >> 8o, masked to n bytes, upper bits zero.
- DONE: memory_ready = 1 while memory_enable high; memory_enable low → IDLE, ready low next cycle.
- memory_enable dropped before DONE: SRAM transactions still complete (no partial writes); DONE exits immediately, so ready is never asserted for that request.
- Input changes after latch ignored until IDLE.

## Timing
- Reset: state IDLE; memory_ready, sram_enable, sram_write, sram_byte_enable, sram_address, sram_write_data, memory_data_in all 0.
- Cycle 0 = enable first high in IDLE. Strobe in cycle 1.
- Aligned read: ready cycle 2+READ_LATENCY. Split read: high strobe cycle 2+READ_LATENCY, ready cycle 3+2·READ_LATENCY.
- Aligned write: ready cycle 2. Split write: strobes cycles 1 and 2, ready cycle 3.
- All outputs registered; no combinational path from memory_* inputs to outputs.
- Back-to-back: after enable drops in DONE, IDLE one cycle, then next request may be latched.
- Reset asserted mid-transaction: immediate return to IDLE, outputs to reset values; split write may be left half done.

## Structure
- Shared package: size codes, operation codes, state enumeration.
- Sub-module memory_lane_shifter: combinational byte-enable and write/read lane steering from size and offset, instanced once.

## Test plan
- Aligned word write 0xDEADBEEF @0x100, then read @0x100 → strobe word 0x40, byte_enable 0xF; read returns 0xDEADBEEF, ready cycle 3 with READ_LATENCY=1.
- Byte write 0xAB @0x203 → byte_enable 0x8, write_data 0xAB000000; byte read returns 0x000000AB.
- Split word write 0x11223344 @0x301 → strobes word 0xC0 be 0xE data 0x22334400, word 0xC1 be 0x1 data 0x00000011; read back 0x11223344, ready cycle 5.
- Half write @0xFFFFFFFF → second strobe word address 0 be 0x1 (wrap).
- Enable dropped in WAIT_LOW of read → ready never high, return IDLE; next request serviced normally.
- reset_n low during ACCESS_HIGH → all outputs 0 same cycle; next request starts from IDLE.

Source files
------------

// File: rtl/memory_sram_adapter_pkg.sv
// Shared types for the SRAM adapter: access size codes, operation codes, FSM states.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package memory_sram_adapter_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE     = 2'd0,
    SIZE_HALF     = 2'd1,
    SIZE_WORD     = 2'd2,
    SIZE_WORD_ALT = 2'd3
  } size_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_ACCESS_LOW  = 3'd1,
    ST_WAIT_LOW    = 3'd2,
    ST_ACCESS_HIGH = 3'd3,
    ST_WAIT_HIGH   = 3'd4,
    ST_DONE        = 3'd5
  } state_e;

  // Byte count for a size code; code 3 behaves as a full word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_bytes = 3'd1;
      SIZE_HALF: size_bytes = 3'd2;
      default:   size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/memory_lane_shifter.sv
// Byte-lane steering: byte enables and write data for both halves of a (possibly split) access, plus read alignment.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module memory_lane_shifter
  import memory_sram_adapter_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_lo_i,
  input  logic [31:0] rdata_hi_i,
  output logic        split_o,
  output logic [3:0]  be_lo_o,
  output logic [3:0]  be_hi_o,
  output logic [31:0] wdata_lo_o,
  output logic [31:0] wdata_hi_o,
  output logic [31:0] rdata_o
);

  logic [2:0]  nbytes;
  logic [3:0]  span;
  logic [7:0]  mask8;
  logic [63:0] wide_w;
  logic [63:0] wide_r;
  logic [31:0] rmask;

  // An 8-lane mask over two adjacent words: the low nibble is the first
  // transaction, the high nibble the spill-over into the next word.
  always_comb begin
    nbytes     = size_bytes(size_i);
    span       = {2'b00, offset_i} + {1'b0, nbytes};
    split_o    = (span > 4'd4);
    mask8      = ((8'd1 << nbytes) - 8'd1) << offset_i;
    be_lo_o    = mask8[3:0];
    be_hi_o    = mask8[7:4];
    wide_w     = {32'd0, wdata_i} << {offset_i, 3'b000};
    wdata_lo_o = wide_w[31:0];
    wdata_hi_o = wide_w[63:32];
    wide_r     = {rdata_hi_i, rdata_lo_i} >> {offset_i, 3'b000};
    case (nbytes)
      3'd1:    rmask = 32'h0000_00FF;
      3'd2:    rmask = 32'h0000_FFFF;
      default: rmask = 32'hFFFF_FFFF;
    endcase
    rdata_o = wide_r[31:0] & rmask;
  end

endmodule

// File: rtl/memory_sram_adapter.sv
// Arbiter-to-SRAM bridge: enable/ready request in, one or two word-wide SRAM strobes out (split at word boundary).
// Latency: aligned write ready cycle 2, aligned read 2+READ_LATENCY; split adds one strobe (write) or strobe+latency (read).
// Backpressure: ready is held until enable drops; a request abandoned early still finishes its SRAM strobes silently.
module memory_sram_adapter
  import memory_sram_adapter_pkg::*;
#(
  parameter int SIZE         = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            memory_enable,
  input  logic            memory_operation,
  output logic            memory_ready,
  input  logic [1:0]      memory_data_size,
  input  logic [SIZE-1:0] memory_address,
  output logic [31:0]     memory_data_in,
  input  logic [31:0]     memory_data_out,
  output logic            sram_enable,
  output logic            sram_write,
  output logic [SIZE-3:0] sram_address,
  output logic [3:0]      sram_byte_enable,
  output logic [31:0]     sram_write_data,
  input  logic [31:0]     sram_read_data
);

  localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY + 1) : 1;

  state_e          state_q, state_d;
  logic            op_q, op_d;
  logic [1:0]      size_q, size_d;
  logic [SIZE-1:0] addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     lo_q, lo_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            aborted_q, aborted_d;
  logic            ready_q, ready_d;
  logic [31:0]     data_in_q, data_in_d;
  logic            sen_q, sen_d;
  logic            swr_q, swr_d;
  logic [SIZE-3:0] saddr_q, saddr_d;
  logic [3:0]      sbe_q, sbe_d;
  logic [31:0]     swd_q, swd_d;

  logic            idle;
  logic [1:0]      sel_size;
  logic [1:0]      sel_off;
  logic [31:0]     sel_wdata;
  logic [31:0]     rd_lo;
  logic            split;
  logic [3:0]      be_lo, be_hi;
  logic [31:0]     wd_lo, wd_hi;
  logic [31:0]     rdata;
  logic            abort_now;
  logic            lat_done;

  // In IDLE the first strobe is computed from the live request so it can be
  // registered on the same edge that latches it; afterwards the latched copy is used.
  assign idle      = (state_q == ST_IDLE);
  assign sel_size  = idle ? memory_data_size     : size_q;
  assign sel_off   = idle ? memory_address[1:0]  : addr_q[1:0];
  assign sel_wdata = idle ? memory_data_out      : wdata_q;
  assign rd_lo     = (state_q == ST_WAIT_HIGH) ? lo_q : sram_read_data;
  assign abort_now = aborted_q | ~memory_enable;
  assign lat_done  = (cnt_q == CW'(READ_LATENCY));

  memory_lane_shifter u_shifter (
    .size_i     (sel_size),
    .offset_i   (sel_off),
    .wdata_i    (sel_wdata),
    .rdata_lo_i (rd_lo),
    .rdata_hi_i (sram_read_data),
    .split_o    (split),
    .be_lo_o    (be_lo),
    .be_hi_o    (be_hi),
    .wdata_lo_o (wd_lo),
    .wdata_hi_o (wd_hi),
    .rdata_o    (rdata)
  );

  // Next-state and registered-output logic; SRAM outputs default to idle (all zero) every cycle.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    aborted_d = aborted_q | ~memory_enable;
    ready_d   = 1'b0;
    data_in_d = data_in_q;
    sen_d     = 1'b0;
    swr_d     = 1'b0;
    saddr_d   = '0;
    sbe_d     = 4'd0;
    swd_d     = 32'd0;
    case (state_q)
      ST_IDLE: begin
        aborted_d = 1'b0;
        data_in_d = 32'd0;
        if (memory_enable) begin
          op_d    = memory_operation;
          size_d  = memory_data_size;
          addr_d  = memory_address;
          wdata_d = memory_data_out;
          state_d = ST_ACCESS_LOW;
          sen_d   = 1'b1;
          swr_d   = memory_operation;
          saddr_d = memory_address[SIZE-1:2];
          sbe_d   = be_lo;
          swd_d   = (memory_operation == OP_WRITE) ? wd_lo : 32'd0;
        end
      end
      ST_ACCESS_LOW: begin
        if (op_q == OP_READ) begin
          state_d = ST_WAIT_LOW;
          cnt_d   = CW'(1);
        end else if (split) begin
          state_d = ST_ACCESS_HIGH;
          sen_d   = 1'b1;
          swr_d   = 1'b1;
          saddr_d = addr_q[SIZE-1:2] + (SIZE-2)'(1);
          sbe_d   = be_hi;
          swd_d   = wd_hi;
        end else begin
          state_d = ST_DONE;
          ready_d = ~abort_now;
        end
      end
      ST_WAIT_LOW: begin
        if (lat_done) begin
          lo_d = sram_read_data;
          if (split) begin
            state_d = ST_ACCESS_HIGH;
            sen_d   = 1'b1;
            saddr_d = addr_q[SIZE-1:2] + (SIZE-2)'(1);
            sbe_d   = be_hi;
          end else begin
            state_d   = ST_DONE;
            ready_d   = ~abort_now;
            data_in_d = rdata;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_ACCESS_HIGH: begin
        if (op_q == OP_READ) begin
          state_d = ST_WAIT_HIGH;
          cnt_d   = CW'(1);
        end else begin
          state_d = ST_DONE;
          ready_d = ~abort_now;
        end
      end
      ST_WAIT_HIGH: begin
        if (lat_done) begin
          state_d   = ST_DONE;
          ready_d   = ~abort_now;
          data_in_d = rdata;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        if (abort_now) begin
          state_d   = ST_IDLE;
          data_in_d = 32'd0;
        end else begin
          ready_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, latched request and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      op_q      <= 1'b0;
      size_q    <= 2'd0;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
      lo_q      <= 32'd0;
      cnt_q     <= '0;
      aborted_q <= 1'b0;
      ready_q   <= 1'b0;
      data_in_q <= 32'd0;
      sen_q     <= 1'b0;
      swr_q     <= 1'b0;
      saddr_q   <= '0;
      sbe_q     <= 4'd0;
      swd_q     <= 32'd0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      aborted_q <= aborted_d;
      ready_q   <= ready_d;
      data_in_q <= data_in_d;
      sen_q     <= sen_d;
      swr_q     <= swr_d;
      saddr_q   <= saddr_d;
      sbe_q     <= sbe_d;
      swd_q     <= swd_d;
    end
  end

  assign memory_ready     = ready_q;
  assign memory_data_in   = data_in_q;
  assign sram_enable      = sen_q;
  assign sram_write       = swr_q;
  assign sram_address     = saddr_q;
  assign sram_byte_enable = sbe_q;
  assign sram_write_data  = swd_q;

endmodule

// File: tb/tb_memory_sram_adapter.sv
// Directed bench with an SRAM behavioural model; expected strobes and responses are queued and checked by a monitor.
module tb_memory_sram_adapter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        memory_enable = 1'b0;
  logic        memory_operation = 1'b0;
  logic        memory_ready;
  logic [1:0]  memory_data_size = 2'd0;
  logic [31:0] memory_address = 32'd0;
  logic [31:0] memory_data_in;
  logic [31:0] memory_data_out = 32'd0;
  logic        sram_enable;
  logic        sram_write;
  logic [29:0] sram_address;
  logic [3:0]  sram_byte_enable;
  logic [31:0] sram_write_data;
  logic [31:0] sram_read_data = 32'd0;

  memory_sram_adapter #(.SIZE(32), .READ_LATENCY(1)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .memory_enable    (memory_enable),
    .memory_operation (memory_operation),
    .memory_ready     (memory_ready),
    .memory_data_size (memory_data_size),
    .memory_address   (memory_address),
    .memory_data_in   (memory_data_in),
    .memory_data_out  (memory_data_out),
    .sram_enable      (sram_enable),
    .sram_write       (sram_write),
    .sram_address     (sram_address),
    .sram_byte_enable (sram_byte_enable),
    .sram_write_data  (sram_write_data),
    .sram_read_data   (sram_read_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [29:0] addr;
    logic [3:0]  be;
    logic        wr;
    logic [31:0] wd;
    int          rel;
  } strobe_t;

  typedef struct {
    logic [31:0] data;
    logic        chk_data;
    int          rel;
  } rsp_t;

  strobe_t sq[$];
  rsp_t    rq[$];
  strobe_t ms;
  rsp_t    mr;
  int      checks = 0;
  int      failures = 0;
  int      cyc = 0;
  int      t0 = 0;
  logic    prev_ready = 1'b0;

  logic [31:0] mem [logic [29:0]];
  logic [31:0] w;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic push_strobe(input logic [29:0] a, input logic [3:0] be, input logic wr,
                             input logic [31:0] wd, input int rel);
    strobe_t s;
    s.addr = a; s.be = be; s.wr = wr; s.wd = wd; s.rel = rel;
    sq.push_back(s);
  endtask

  task automatic push_rsp(input logic [31:0] d, input logic chk, input int rel);
    rsp_t r;
    r.data = d; r.chk_data = chk; r.rel = rel;
    rq.push_back(r);
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // SRAM model, read latency one cycle.
  always @(posedge clock) begin
    if (sram_enable) begin
      w = mem.exists(sram_address) ? mem[sram_address] : 32'd0;
      if (sram_write) begin
        for (int i = 0; i < 4; i++)
          if (sram_byte_enable[i]) w[8*i +: 8] = sram_write_data[8*i +: 8];
        mem[sram_address] = w;
      end else begin
        sram_read_data <= w;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT strobes the SRAM or raises ready.
  always @(negedge clock) begin
    if (reset_n) begin
      if (sram_enable) begin
        if (sq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_strobe actual=addr 0x%0h expected=no strobe", sram_address);
        end else begin
          ms = sq.pop_front();
          check("strobe_addr", 64'(sram_address), 64'(ms.addr));
          check("strobe_be", 64'(sram_byte_enable), 64'(ms.be));
          check("strobe_write", 64'(sram_write), 64'(ms.wr));
          check("strobe_cycle", 64'(cyc - t0), 64'(ms.rel));
          if (ms.wr) check("strobe_wdata", 64'(sram_write_data), 64'(ms.wd));
        end
      end
      if (memory_ready && !prev_ready) begin
        if (rq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_ready actual=1 expected=0");
        end else begin
          mr = rq.pop_front();
          check("ready_cycle", 64'(cyc - t0), 64'(mr.rel));
          if (mr.chk_data) check("read_data", 64'(memory_data_in), 64'(mr.data));
        end
      end
    end
    prev_ready = memory_ready;
  end

  task automatic start(input logic op, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    @(posedge clock); #1;
    memory_enable = 1'b1; memory_operation = op; memory_data_size = sz;
    memory_address = a; memory_data_out = d;
    t0 = cyc;
  endtask

  task automatic do_req(input logic op, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int waited;
    start(op, sz, a, d);
    waited = 0;
    while (!memory_ready && waited < 40) begin
      @(posedge clock); #1;
      waited++;
      memory_data_out = ~d;  // post-latch changes must be ignored
    end
    if (!memory_ready) begin
      checks++; failures++;
      $display("FAIL ready_timeout actual=0 expected=1");
    end
    @(posedge clock); #1;
    check("ready_held", 64'(memory_ready), 64'd1);
    memory_enable = 1'b0;
    @(posedge clock); #1;
    check("ready_drop", 64'(memory_ready), 64'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ready"}, 64'(memory_ready), 64'd0);
    check({tag, "_sram_en"}, 64'(sram_enable), 64'd0);
    check({tag, "_sram_wr"}, 64'(sram_write), 64'd0);
    check({tag, "_sram_be"}, 64'(sram_byte_enable), 64'd0);
    check({tag, "_sram_addr"}, 64'(sram_address), 64'd0);
    check({tag, "_sram_wd"}, 64'(sram_write_data), 64'd0);
    check({tag, "_data_in"}, 64'(memory_data_in), 64'd0);
  endtask

  initial begin
    #12;
    check_outputs_zero("reset");
    @(negedge clock);
    reset_n = 1'b1;

    // Aligned word write and read-back.
    push_strobe(30'h40, 4'hF, 1'b1, 32'hDEADBEEF, 1); push_rsp(32'h0, 1'b0, 2);
    do_req(1'b1, 2'd2, 32'h100, 32'hDEADBEEF);
    push_strobe(30'h40, 4'hF, 1'b0, 32'h0, 1); push_rsp(32'hDEADBEEF, 1'b1, 3);
    do_req(1'b0, 2'd2, 32'h100, 32'h0);

    // Byte in top lane.
    push_strobe(30'h80, 4'h8, 1'b1, 32'hAB000000, 1); push_rsp(32'h0, 1'b0, 2);
    do_req(1'b1, 2'd0, 32'h203, 32'h000000AB);
    push_strobe(30'h80, 4'h8, 1'b0, 32'h0, 1); push_rsp(32'h000000AB, 1'b1, 3);
    do_req(1'b0, 2'd0, 32'h203, 32'h0);

    // Split word write and read.
    push_strobe(30'hC0, 4'hE, 1'b1, 32'h22334400, 1);
    push_strobe(30'hC1, 4'h1, 1'b1, 32'h00000011, 2); push_rsp(32'h0, 1'b0, 3);
    do_req(1'b1, 2'd2, 32'h301, 32'h11223344);
    push_strobe(30'hC0, 4'hE, 1'b0, 32'h0, 1);
    push_strobe(30'hC1, 4'h1, 1'b0, 32'h0, 3); push_rsp(32'h11223344, 1'b1, 5);
    do_req(1'b0, 2'd2, 32'h301, 32'h0);

    // Half at the top of the address space wraps to word 0.
    push_strobe(30'h3FFFFFFF, 4'h8, 1'b1, 32'h34000000, 1);
    push_strobe(30'h0, 4'h1, 1'b1, 32'h00000012, 2); push_rsp(32'h0, 1'b0, 3);
    do_req(1'b1, 2'd1, 32'hFFFFFFFF, 32'h00001234);
    push_strobe(30'h3FFFFFFF, 4'h8, 1'b0, 32'h0, 1);
    push_strobe(30'h0, 4'h1, 1'b0, 32'h0, 3); push_rsp(32'h00001234, 1'b1, 5);
    do_req(1'b0, 2'd1, 32'hFFFFFFFF, 32'h0);

    // Half read from the upper lanes; size code 3 as word.
    push_strobe(30'h40, 4'hC, 1'b0, 32'h0, 1); push_rsp(32'h0000DEAD, 1'b1, 3);
    do_req(1'b0, 2'd1, 32'h102, 32'h0);
    push_strobe(30'h40, 4'hF, 1'b0, 32'h0, 1); push_rsp(32'hDEADBEEF, 1'b1, 3);
    do_req(1'b0, 2'd3, 32'h100, 32'h0);

    // Enable withdrawn during WAIT_LOW: strobe still happens, ready never rises.
    push_strobe(30'h40, 4'hF, 1'b0, 32'h0, 1);
    start(1'b0, 2'd2, 32'h100, 32'h0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    memory_enable = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    check("abort_ready_low", 64'(memory_ready), 64'd0);
    push_strobe(30'h80, 4'h8, 1'b0, 32'h0, 1); push_rsp(32'h000000AB, 1'b1, 3);
    do_req(1'b0, 2'd0, 32'h203, 32'h0);

    // Reset during ACCESS_HIGH of a split write: only the low half lands.
    push_strobe(30'hC0, 4'hE, 1'b1, 32'h66778800, 1);
    start(1'b1, 2'd2, 32'h301, 32'h55667788);
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("pre_reset_high_strobe", 64'(sram_enable), 64'd1);
    reset_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    memory_enable = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    push_strobe(30'hC0, 4'hE, 1'b0, 32'h0, 1);
    push_strobe(30'hC1, 4'h1, 1'b0, 32'h0, 3); push_rsp(32'h11667788, 1'b1, 5);
    do_req(1'b0, 2'd2, 32'h301, 32'h0);

    repeat (3) @(posedge clock);
    #1;
    check("strobes_left", 64'(sq.size()), 64'd0);
    check("responses_left", 64'(rq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
